// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - coin sensor debounce, credit accumulation and timed change payout
module coin_acceptor #(
    parameter int DEB_CYCLES = 4,
    parameter int PRICE      = 4,
    parameter int VAL0       = 1,
    parameter int VAL1       = 2,
    parameter int CHG_GAP    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_raw,
    input  logic       coin_type_raw,
    input  logic       refund,
    input  logic       vend_done,
    output logic       hm,
    output logic       tm,
    output logic [3:0] credit,
    output logic       coin_ok,
    output logic       coin_rej,
    output logic       change_pulse,
    output logic       busy
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int GW = $clog2(CHG_GAP + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(CHG_GAP - 1);
    localparam logic [5:0] PRICE6 = 6'(PRICE);
    localparam logic [5:0] VAL0_6 = 6'(VAL0);
    localparam logic [5:0] VAL1_6 = 6'(VAL1);
    localparam logic [3:0] PRICE4 = 4'(PRICE);
    localparam logic [3:0] VAL0_4 = 4'(VAL0);
    localparam logic [3:0] VAL1_4 = 4'(VAL1);

    typedef enum logic {ARMED, RELEASE} deb_t;
    typedef enum logic [1:0] {IDLE, PAY, GAP} rf_t;

    logic coin_s1, coin_s2, typ_s1, typ_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coin_s1 <= 1'b0;
            coin_s2 <= 1'b0;
            typ_s1  <= 1'b0;
            typ_s2  <= 1'b0;
        end else begin
            coin_s1 <= coin_raw;
            coin_s2 <= coin_s1;
            typ_s1  <= coin_type_raw;
            typ_s2  <= typ_s1;
        end
    end

    deb_t          deb_state, deb_next;
    logic [DW-1:0] deb_cnt, deb_cnt_n;
    logic          acc_n, acc_evt, acc_typ;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_state <= ARMED;
            deb_cnt   <= '0;
            acc_evt   <= 1'b0;
            acc_typ   <= 1'b0;
        end else begin
            deb_state <= deb_next;
            deb_cnt   <= deb_cnt_n;
            acc_evt   <= acc_n;
            if (acc_n)
                acc_typ <= typ_s2;
        end
    end

    // The accept event is registered once more so the credit update lands on edge 2+DEB_CYCLES.
    always_comb begin
        deb_next  = deb_state;
        deb_cnt_n = deb_cnt;
        acc_n     = 1'b0;
        case (deb_state)
            ARMED: begin
                if (coin_s2) begin
                    if (deb_cnt == DEB_LAST) begin
                        acc_n     = 1'b1;
                        deb_next  = RELEASE;
                        deb_cnt_n = '0;
                    end else begin
                        deb_cnt_n = deb_cnt + 1'b1;
                    end
                end else begin
                    deb_cnt_n = '0;
                end
            end
            default: begin
                if (!coin_s2) begin
                    if (deb_cnt == DEB_LAST) begin
                        deb_next  = ARMED;
                        deb_cnt_n = '0;
                    end else begin
                        deb_cnt_n = deb_cnt + 1'b1;
                    end
                end else begin
                    deb_cnt_n = '0;
                end
            end
        endcase
    end

    rf_t           rf_state, rf_next;
    logic [GW-1:0] gap_cnt, gap_cnt_n;
    logic [3:0]    credit_n, base4;
    logic [5:0]    cr6, v6, sum6;
    logic          ded, rej, okk, pay, tm_n, busy_n;

    assign cr6 = {2'b00, credit};
    assign hm  = (cr6 >= PRICE6);

    always_comb begin
        v6        = acc_typ ? VAL1_6 : VAL0_6;
        ded       = vend_done && !busy && (cr6 >= PRICE6);
        sum6      = cr6 + v6 - (ded ? PRICE6 : 6'd0);
        rej       = acc_evt && (busy || (sum6 > 6'd15));
        okk       = acc_evt && !rej;
        base4     = credit + (okk ? (acc_typ ? VAL1_4 : VAL0_4) : 4'd0) - (ded ? PRICE4 : 4'd0);
        tm_n      = okk ? acc_typ : tm;
        rf_next   = rf_state;
        gap_cnt_n = gap_cnt;
        pay       = 1'b0;
        case (rf_state)
            IDLE: begin
                // A refund only starts if something is left after any same-cycle deduction.
                if (refund && (credit != 4'd0) && (base4 != 4'd0)) begin
                    pay     = 1'b1;
                    rf_next = PAY;
                end
            end
            PAY: begin
                rf_next   = GAP;
                gap_cnt_n = '0;
            end
            default: begin
                if (gap_cnt == GAP_LAST) begin
                    if (credit != 4'd0) begin
                        pay     = 1'b1;
                        rf_next = PAY;
                    end else begin
                        rf_next = IDLE;
                    end
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
        endcase
        credit_n = base4 - (pay ? 4'd1 : 4'd0);
        busy_n   = (rf_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_state     <= IDLE;
            gap_cnt      <= '0;
            credit       <= 4'd0;
            tm           <= 1'b0;
            coin_ok      <= 1'b0;
            coin_rej     <= 1'b0;
            change_pulse <= 1'b0;
            busy         <= 1'b0;
        end else begin
            rf_state     <= rf_next;
            gap_cnt      <= gap_cnt_n;
            credit       <= credit_n;
            tm           <= tm_n;
            coin_ok      <= okk;
            coin_rej     <= rej;
            change_pulse <= pay;
            busy         <= busy_n;
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - scoreboard bench for coin_acceptor
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin_raw = 1'b0;
    logic       coin_type_raw = 1'b0;
    logic       refund = 1'b0;
    logic       vend_done = 1'b0;
    logic       hm, tm, coin_ok, coin_rej, change_pulse, busy;
    logic [3:0] credit;

    coin_acceptor dut (
        .clk(clk), .rst(rst), .coin_raw(coin_raw), .coin_type_raw(coin_type_raw),
        .refund(refund), .vend_done(vend_done), .hm(hm), .tm(tm), .credit(credit),
        .coin_ok(coin_ok), .coin_rej(coin_rej), .change_pulse(change_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int kind;
        int credit;
        int tm;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int k, input int cr, input int t);
        ev_t e;
        e.cyc = c; e.kind = k; e.credit = cr; e.tm = t;
        exp_q.push_back(e);
    endtask

    // kind: 0 = coin_ok, 1 = coin_rej, 2 = change_pulse
    task automatic mon(input int k);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_output_kind", k, -1);
        end else begin
            e = exp_q.pop_front();
            check("evt_kind", k, e.kind);
            check("evt_cycle", cyc, e.cyc);
            check("evt_credit", int'(credit), e.credit);
            check("evt_tm", int'(tm), e.tm);
            check("evt_hm", int'(hm), int'(e.credit >= 4));
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (coin_ok) mon(0);
            if (coin_rej) mon(1);
            if (change_pulse) mon(2);
        end
    end

    // pat is the raw sensor level per cycle, LSB first; acc_off is the output edge relative to the first high edge.
    task automatic insert(input logic [31:0] pat, input int len, input logic typ, input int acc_off,
                          input int vend_at, input int kind, input int cr, input int t);
        int e0;
        @(negedge clk);
        e0 = cyc + 1;
        if (acc_off >= 0) push(e0 + acc_off, kind, cr, t);
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            coin_raw      = pat[i];
            coin_type_raw = typ;
            vend_done     = (i == vend_at);
        end
        @(negedge clk);
        coin_raw  = 1'b0;
        vend_done = 1'b0;
    endtask

    task automatic vend(input int exp_cr);
        @(negedge clk);
        vend_done = 1'b1;
        @(negedge clk);
        vend_done = 1'b0;
        check("vend_credit", int'(credit), exp_cr);
        check("vend_hm", int'(hm), int'(exp_cr >= 4));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_credit"}, int'(credit), 0);
        check({tag, "_flags"}, int'({hm, tm, coin_ok, coin_rej, change_pulse, busy}), 0);
    endtask

    int k;

    initial begin
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        insert(32'h3FF, 20, 1'b1, 6, -1, 0, 2, 1);
        insert(32'h3FF, 20, 1'b1, 6, -1, 0, 4, 1);

        insert(32'h7, 13, 1'b0, -1, -1, 0, 0, 0);
        insert(32'hF7, 18, 1'b0, 10, -1, 0, 5, 0);

        insert(32'h3FF, 20, 1'b0, 6, 6, 0, 2, 0);
        vend(2);

        for (int i = 0; i < 5; i++) insert(32'h3FF, 20, 1'b1, 6, -1, 0, 4 + 2 * i, 1);
        insert(32'h3FF, 20, 1'b0, 6, -1, 0, 13, 0);
        insert(32'h3FF, 20, 1'b0, 6, -1, 0, 14, 0);
        insert(32'h3FF, 20, 1'b1, 6, -1, 1, 14, 0);
        insert(32'h3FF, 20, 1'b0, 6, -1, 0, 15, 0);

        vend(11);
        vend(7);
        vend(3);

        @(negedge clk);
        k = cyc + 1;
        refund        = 1'b1;
        coin_raw      = 1'b1;
        coin_type_raw = 1'b1;
        push(k, 2, 2, 0);
        push(k + 6, 1, 2, 0);
        push(k + 9, 2, 1, 0);
        push(k + 18, 2, 0, 0);
        for (int i = 1; i <= 27; i++) begin
            @(negedge clk);
            refund = 1'b0;
            if (i == 6) coin_raw = 1'b0;
            if (i == 27) check("busy_before_end", int'(busy), 1);
        end
        @(negedge clk);
        check("busy_fall", int'(busy), 0);
        check("credit_after_refund", int'(credit), 0);

        insert(32'h3FF, 20, 1'b1, 6, -1, 0, 2, 1);
        @(negedge clk);
        k = cyc + 1;
        refund = 1'b1;
        push(k, 2, 1, 1);
        @(negedge clk);
        refund = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_mid_refund", int'(busy), 1);
        #2 rst = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("credit_post_reset", int'(credit), 0);
        check("busy_post_reset", int'(busy), 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
